x_23k640_target: RTL

X_23K640_TARGET -- requirements
Module: x_23k640_target

---
 rtl/x_23K640_pkg.sv | 34 +++
 rtl/x_23K640_sync.sv | 31 +++
 rtl/x_23k640_target.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/x_23K640_pkg.sv
// Shared opcodes, address-mode encodings and FSM state type for the 23K640-style SPI SRAM target.
package x_23K640_pkg;

    localparam logic [7:0] OP_WRSR  = 8'h01;
    localparam logic [7:0] OP_WRITE = 8'h02;
    localparam logic [7:0] OP_READ  = 8'h03;
    localparam logic [7:0] OP_RDSR  = 8'h05;

    localparam logic [1:0] MODE_BYTE = 2'b00;
    localparam logic [1:0] MODE_SEQ  = 2'b01;
    localparam logic [1:0] MODE_PAGE = 2'b10;
    localparam logic [1:0] MODE_RSVD = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        RD_DATA,
        WR_DATA,
        SR_WR,
        SR_RD,
        IGNORE
    } state_t;

    // The reserved encoding behaves exactly like byte mode.
    function automatic logic is_byte_mode(input logic [1:0] mode);
        case (mode)
            MODE_SEQ, MODE_PAGE:  return 1'b0;
            MODE_BYTE, MODE_RSVD: return 1'b1;
            default:              return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/x_23K640_sync.sv
// Multi-flop synchroniser for one asynchronous SPI pin, with rise/fall detection on the synchronised value.
module x_23K640_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] chain;
    logic              prev;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            chain <= {STAGES{RST_VAL}};
            prev  <= RST_VAL;
        end else begin
            chain <= {chain[STAGES-2:0], i_d};
            prev  <= chain[STAGES-1];
        end
    end

    assign o_q    = chain[STAGES-1];
    assign o_rise = o_q & ~prev;
    assign o_fall = ~o_q & prev;

endmodule

// File: rtl/x_23k640_target.sv
// SPI mode-0 slave speaking the 23K640 serial SRAM protocol; the byte array itself sits behind a simple strobe port.
module x_23k640_target
    import x_23K640_pkg::*;
#(
    parameter int ADDR_W      = 13,
    parameter int SYNC_STAGES = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_cs,
    input  logic              i_sck,
    input  logic              i_si,
    output logic              o_so,
    output logic              o_mem_valid,
    output logic              o_mem_rd_n_wr,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [7:0]        o_mem_wdata,
    input  logic [7:0]        i_mem_rdata,
    output state_t            o_dbg_state
);

    // Memory port: o_mem_valid is a one-cycle strobe with no back-pressure; for a read,
    // i_mem_rdata must hold the byte in the cycle right after the strobe.

    logic cs_s, cs_rise, cs_fall;
    logic sck_s, sck_rise, sck_fall;
    logic si_s, si_rise, si_fall;

    x_23K640_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .i_clk(i_clk), .i_rst(i_rst), .i_d(i_cs),
        .o_q(cs_s), .o_rise(cs_rise), .o_fall(cs_fall)
    );
    x_23K640_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
        .i_clk(i_clk), .i_rst(i_rst), .i_d(i_sck),
        .o_q(sck_s), .o_rise(sck_rise), .o_fall(sck_fall)
    );
    x_23K640_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_si (
        .i_clk(i_clk), .i_rst(i_rst), .i_d(i_si),
        .o_q(si_s), .o_rise(si_rise), .o_fall(si_fall)
    );

    state_t            state;
    logic [3:0]        cnt;
    logic [15:0]       shreg;
    logic [7:0]        shift_out;
    logic [7:0]        rbuf;
    logic [7:0]        status;
    logic [ADDR_W-1:0] addr;
    logic              is_read;
    logic              load_next;
    logic              rd_wait;

    logic              rise_ev, fall_ev, byte_mode;
    logic [15:0]       sh_next;
    logic [7:0]        load_src;
    logic [ADDR_W-1:0] addr_next;

    assign rise_ev   = sck_rise & ~cs_s;
    assign fall_ev   = sck_fall & ~cs_s;
    assign sh_next   = {shreg[14:0], si_s};
    assign byte_mode = is_byte_mode(status[7:6]);
    assign load_src  = (state == SR_RD) ? status : rbuf;

    // Page mode keeps everything above the 32-byte page and lets only the low 5 bits roll over.
    always_comb begin
        addr_next = addr + ADDR_W'(1);
        if (status[7:6] == MODE_PAGE) begin
            addr_next[ADDR_W-1:5] = addr[ADDR_W-1:5];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state         <= IDLE;
            cnt           <= '0;
            shreg         <= '0;
            shift_out     <= '0;
            rbuf          <= '0;
            status        <= '0;
            addr          <= '0;
            is_read       <= 1'b0;
            load_next     <= 1'b0;
            rd_wait       <= 1'b0;
            o_so          <= 1'b0;
            o_mem_valid   <= 1'b0;
            o_mem_rd_n_wr <= 1'b1;
            o_mem_addr    <= '0;
            o_mem_wdata   <= '0;
        end else begin
            o_mem_valid <= 1'b0;
            rd_wait     <= o_mem_valid & o_mem_rd_n_wr;
            if (rd_wait) begin
                rbuf <= i_mem_rdata;
            end

            if (cs_rise) begin
                state     <= IDLE;
                cnt       <= '0;
                load_next <= 1'b0;
                o_so      <= 1'b0;
            end else if (cs_fall) begin
                state     <= CMD;
                cnt       <= '0;
                load_next <= 1'b0;
                o_so      <= 1'b0;
            end else if (rise_ev) begin
                cnt   <= cnt + 4'd1;
                shreg <= sh_next;
                case (state)
                    CMD: if (cnt == 4'd7) begin
                        cnt <= '0;
                        case (sh_next[7:0])
                            OP_READ:  begin state <= ADDR; is_read <= 1'b1; end
                            OP_WRITE: begin state <= ADDR; is_read <= 1'b0; end
                            OP_WRSR:  state <= SR_WR;
                            OP_RDSR:  begin state <= SR_RD; load_next <= 1'b1; end
                            default:  state <= IGNORE;
                        endcase
                    end
                    ADDR: if (cnt == 4'd15) begin
                        cnt  <= '0;
                        addr <= sh_next[ADDR_W-1:0];
                        if (is_read) begin
                            state         <= RD_DATA;
                            o_mem_valid   <= 1'b1;
                            o_mem_rd_n_wr <= 1'b1;
                            o_mem_addr    <= sh_next[ADDR_W-1:0];
                            load_next     <= 1'b1;
                        end else begin
                            state <= WR_DATA;
                        end
                    end
                    // Bit 0 of the current byte just went out: prefetch the next byte.
                    RD_DATA: if (cnt == 4'd7) begin
                        cnt <= '0;
                        if (byte_mode) begin
                            state <= IGNORE;
                            o_so  <= 1'b0;
                        end else begin
                            addr          <= addr_next;
                            o_mem_valid   <= 1'b1;
                            o_mem_rd_n_wr <= 1'b1;
                            o_mem_addr    <= addr_next;
                            load_next     <= 1'b1;
                        end
                    end
                    WR_DATA: if (cnt == 4'd7) begin
                        cnt           <= '0;
                        o_mem_valid   <= 1'b1;
                        o_mem_rd_n_wr <= 1'b0;
                        o_mem_addr    <= addr;
                        o_mem_wdata   <= sh_next[7:0];
                        if (byte_mode) begin
                            state <= IGNORE;
                        end else begin
                            addr <= addr_next;
                        end
                    end
                    SR_WR: if (cnt == 4'd7) begin
                        status <= {sh_next[7:6], 5'b00000, sh_next[0]};
                        state  <= IGNORE;
                    end
                    SR_RD: if (cnt == 4'd7) begin
                        cnt       <= '0;
                        load_next <= 1'b1;
                    end
                    default: ;
                endcase
            end else if (fall_ev && (state == RD_DATA || state == SR_RD)) begin
                if (load_next) begin
                    o_so      <= load_src[7];
                    shift_out <= {load_src[6:0], 1'b0};
                    load_next <= 1'b0;
                end else begin
                    o_so      <= shift_out[7];
                    shift_out <= {shift_out[6:0], 1'b0};
                end
            end
        end
    end

    assign o_dbg_state = state;

    logic unused_ok;
    assign unused_ok = ^{si_rise, si_fall, sck_s, shreg[15], sh_next};

endmodule
